// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle datapath control: state codes,
// opcodes, mux/ALU selects and the packed control word.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_EXEC_I = 4'd3,
    ST_ADDR   = 4'd4,
    ST_MEM_RD = 4'd5,
    ST_MEM_WB = 4'd6,
    ST_MEM_WR = 4'd7,
    ST_ALU_WB = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_HALT   = 4'd11
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] OP_BNE  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_ONE  = 2'b01,
    SRCB_IMM  = 2'b10,
    SRCB_BOFS = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

  typedef struct packed {
    logic       pc_write;
    logic       bpc_write;
    logic       nbpc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_src_e    pc_src;
    logic       halted;
  } ctrl_word_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface multicycle_ctrl_fsm_if #(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                PC_write;
  logic                BPC_write;
  logic                NBPC_write;
  logic                IR_write;
  logic                mem_read;
  logic                mem_write;
  logic                iord;
  logic                reg_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_src;
  logic                halted;
  logic                illegal_op;
  logic [CNT_W-1:0]    retire_cnt;

  modport master (
    input  opcode,
    output PC_write, BPC_write, NBPC_write, IR_write, mem_read, mem_write,
           iord, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, pc_src, halted, illegal_op, retire_cnt
  );

  modport slave (
    output opcode,
    input  PC_write, BPC_write, NBPC_write, IR_write, mem_read, mem_write,
           iord, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, pc_src, halted, illegal_op, retire_cnt
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_ctrl_out_decode.sv
// Moore output decode: registered state plus latched opcode -> control word.
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic [3:0] i_op_q,
  output ctrl_word_t o_ctrl
);

  // Every field defaults to 0; each state raises only what it needs.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.alu_src_b = SRCB_ONE;
        o_ctrl.pc_write  = 1'b1;
      end
      ST_DECODE: o_ctrl.alu_src_b = SRCB_BOFS;
      ST_EXEC_R: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      ST_EXEC_I, ST_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      ST_ALU_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = (i_op_q == OP_ADD);
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_op     = ALU_SUB;
        o_ctrl.pc_src     = PCSRC_ALUOUT;
        o_ctrl.bpc_write  = (i_op_q == OP_BEQ);
        o_ctrl.nbpc_write = (i_op_q == OP_BNE);
      end
      ST_JUMP: begin
        o_ctrl.pc_src   = PCSRC_JUMP;
        o_ctrl.pc_write = 1'b1;
      end
      ST_HALT: o_ctrl.halted = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer: state, latched opcode, retire counter and
// sticky illegal flag. Outputs are forced low while reset is held.
//
// state  | meaning
// FETCH  | read instr into IR, PC <= PC + 1
// DECODE | latch opcode, precompute branch target
// EXEC_R | R-type ALU op
// EXEC_I | immediate ALU op
// ADDR   | load/store address compute
// MEM_RD | load data read
// MEM_WB | load write-back
// MEM_WR | store write
// ALU_WB | ALU result write-back
// BRANCH | compare, conditional PC load
// JUMP   | unconditional PC load
// HALT   | parked until reset
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_fsm_if.master bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [3:0]       r_op_q;
  logic [3:0]       w_opc;
  logic [CNT_W-1:0] r_retire_cnt;
  logic             r_illegal_op;
  logic             w_decode_illegal;
  ctrl_word_t       w_ctrl;

  assign w_opc = 4'(bus.opcode);

  // State, opcode latch, retire counter and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_FETCH;
      r_op_q       <= '0;
      r_retire_cnt <= '0;
      r_illegal_op <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_DECODE) r_op_q <= w_opc;
      if (w_decode_illegal) r_illegal_op <= 1'b1;
      if ((w_state_nxt == ST_FETCH) && (r_state != ST_FETCH))
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  // Next-state selection; undefined opcodes retire as a NOP from DECODE.
  always_comb begin
    w_state_nxt      = ST_FETCH;
    w_decode_illegal = 1'b0;
    case (r_state)
      ST_FETCH: w_state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (w_opc)
          OP_ADD:          w_state_nxt = ST_EXEC_R;
          OP_ADDI:         w_state_nxt = ST_EXEC_I;
          OP_LW, OP_SW:    w_state_nxt = ST_ADDR;
          OP_BEQ, OP_BNE:  w_state_nxt = ST_BRANCH;
          OP_JMP:          w_state_nxt = ST_JUMP;
          OP_HALT:         w_state_nxt = ST_HALT;
          default: begin
            w_state_nxt      = ST_FETCH;
            w_decode_illegal = 1'b1;
          end
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: w_state_nxt = ST_ALU_WB;
      ST_ADDR:   w_state_nxt = (r_op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: w_state_nxt = ST_MEM_WB;
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_FETCH;
    endcase
  end

  ctrl_out_decode u_decode (
    .i_state (r_state),
    .i_op_q  (r_op_q),
    .o_ctrl  (w_ctrl)
  );

  assign bus.PC_write   = !reset && w_ctrl.pc_write;
  assign bus.BPC_write  = !reset && w_ctrl.bpc_write;
  assign bus.NBPC_write = !reset && w_ctrl.nbpc_write;
  assign bus.IR_write   = !reset && w_ctrl.ir_write;
  assign bus.mem_read   = !reset && w_ctrl.mem_read;
  assign bus.mem_write  = !reset && w_ctrl.mem_write;
  assign bus.iord       = !reset && w_ctrl.iord;
  assign bus.reg_write  = !reset && w_ctrl.reg_write;
  assign bus.reg_dst    = !reset && w_ctrl.reg_dst;
  assign bus.mem_to_reg = !reset && w_ctrl.mem_to_reg;
  assign bus.alu_src_a  = !reset && w_ctrl.alu_src_a;
  assign bus.alu_src_b  = reset ? 2'b00 : w_ctrl.alu_src_b;
  assign bus.alu_op     = reset ? 2'b00 : w_ctrl.alu_op;
  assign bus.pc_src     = reset ? 2'b00 : w_ctrl.pc_src;
  assign bus.halted     = !reset && w_ctrl.halted;
  assign bus.illegal_op = !reset && r_illegal_op;
  assign bus.retire_cnt = reset ? '0 : r_retire_cnt;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Instruction-level reference model: each opcode maps to a fixed list of
// per-cycle control words; retire count and illegal flag tracked per instr.
module tb_multicycle_ctrl_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] m_cnt = 4'd0;
  logic       m_ill = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.OPCODE_W(4), .CNT_W(4)) bus ();

  multicycle_ctrl_fsm #(.OPCODE_W(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] obs();
    return {bus.PC_write, bus.BPC_write, bus.NBPC_write, bus.IR_write,
            bus.mem_read, bus.mem_write, bus.iord, bus.reg_write, bus.reg_dst,
            bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_src, bus.halted};
  endfunction

  // Cycle k of instruction op, read straight off the per-instruction step list.
  function automatic logic [17:0] exp_vec(input logic [3:0] op, input int k);
    logic pcw = 0, bpc = 0, nbpc = 0, irw = 0, mr = 0, mw = 0, iord = 0;
    logic rw = 0, rd = 0, m2r = 0, sa = 0, h = 0;
    logic [1:0] sb = 0, aop = 0, psrc = 0;
    if (k == 0) begin mr = 1; irw = 1; sb = 2'b01; pcw = 1; end
    else if (k == 1) sb = 2'b11;
    else case (op)
      4'b0000: if (k == 2) begin sa = 1; aop = 2'b10; end else begin rw = 1; rd = 1; end
      4'b0001: if (k == 2) begin sa = 1; sb = 2'b10; end else rw = 1;
      4'b0100: if (k == 2) begin sa = 1; sb = 2'b10; end
               else if (k == 3) begin mr = 1; iord = 1; end
               else begin rw = 1; m2r = 1; end
      4'b0101: if (k == 2) begin sa = 1; sb = 2'b10; end else begin mw = 1; iord = 1; end
      4'b1100, 4'b1101: begin
        sa = 1; aop = 2'b01; psrc = 2'b01;
        bpc = (op == 4'b1100); nbpc = (op == 4'b1101);
      end
      4'b1000: begin psrc = 2'b10; pcw = 1; end
      4'b1111: h = 1;
      default: ;
    endcase
    return {pcw, bpc, nbpc, irw, mr, mw, iord, rw, rd, m2r, sa, sb, aop, psrc, h};
  endfunction

  function automatic int latency(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0101: return 4;
      4'b0100:                   return 5;
      4'b1000, 4'b1100, 4'b1101: return 3;
      default:                   return 2;
    endcase
  endfunction

  function automatic bit is_legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1000, 4'b1100, 4'b1101, 4'b1111};
  endfunction

  task automatic sample(input logic [3:0] op, input int k);
    @(negedge clk);
    chk($sformatf("ctrl op=%b k=%0d", op, k), 32'(obs()), 32'(exp_vec(op, k)));
    chk($sformatf("retire op=%b k=%0d", op, k), 32'(bus.retire_cnt), 32'(m_cnt));
    chk($sformatf("illegal op=%b k=%0d", op, k), 32'(bus.illegal_op), 32'(m_ill));
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [3:0] op);
    bus.opcode = op;
    for (int k = 0; k < latency(op); k++) sample(op, k);
    m_cnt = m_cnt + 4'd1;
    if (!is_legal(op)) m_ill = 1'b1;
  endtask

  task automatic reset_cycles(input int n);
    reset = 1'b1;
    m_cnt = 4'd0;
    m_ill = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("rst_ctrl %0d", i), 32'(obs()), 32'h0);
      chk($sformatf("rst_retire %0d", i), 32'(bus.retire_cnt), 32'h0);
      chk($sformatf("rst_illegal %0d", i), 32'(bus.illegal_op), 32'h0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] op;
    bus.opcode = 4'b0000;
    @(posedge clk); #1;
    reset_cycles(2);

    // Directed: one of each class, then illegal followed by legal ops.
    run_instr(4'b0100);
    run_instr(4'b1100);
    run_instr(4'b1101);
    run_instr(4'b0000);
    run_instr(4'b0001);
    run_instr(4'b0101);
    run_instr(4'b1000);
    run_instr(4'b0110);
    run_instr(4'b0100);
    run_instr(4'b0000);

    // Random instruction stream (HALT excluded so the stream keeps going).
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 14));
      run_instr(op);
    end

    // Abort an LW in MEM_RD with a 3-cycle reset.
    bus.opcode = 4'b0100;
    for (int k = 0; k < 3; k++) sample(4'b0100, k);
    reset_cycles(3);

    // 16 ADDIs wrap the 4-bit retire counter back to 0, then HALT parks.
    for (int i = 0; i < 16; i++) run_instr(4'b0001);
    bus.opcode = 4'b1111;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 0) chk("wrap_to_zero", 32'(bus.retire_cnt), 32'h0);
      chk($sformatf("halt ctrl k=%0d", k), 32'(obs()), 32'(exp_vec(4'b1111, k)));
      chk($sformatf("halt retire k=%0d", k), 32'(bus.retire_cnt), 32'(m_cnt));
      chk($sformatf("halt illegal k=%0d", k), 32'(bus.illegal_op), 32'(m_ill));
      @(posedge clk); #1;
    end

    // Reset out of HALT resumes at FETCH.
    reset_cycles(1);
    run_instr(4'b0001);
    @(negedge clk);
    chk("post_halt_retire", 32'(bus.retire_cnt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
